// File: rtl/tick_enable_gen.sv
// Turns a selected divider bit into single-cycle clock-enable ticks, with run/pause/single-step control.
// Optional COUNT_SAT_EN: tick_count saturates at all-ones instead of wrapping.
module tick_enable_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      divided_clocks,
  input  logic [4:0]       tap_sel,
  input  logic             run,
  input  logic             step_req,
  output logic             tick,
  output logic             step_ack,
  output logic             running,
  output logic [CNT_W-1:0] tick_count
);
  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t           state_q, state_d;
  logic             tap_q, step_q;
  logic [4:0]       tap_sel_q;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             running_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic tap_now, tap_edge, step_rise;

  assign tap_now   = divided_clocks[tap_sel];
  // A tap switch compares against the old tap's history, so suppress the edge that cycle.
  assign tap_edge  = tap_now & ~tap_q & (tap_sel == tap_sel_q);
  assign step_rise = step_req & ~step_q;

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run)            state_d = RUN;
        else if (step_rise) state_d = STEP;
      end
      RUN: begin
        tick_d = tap_edge;
        if (!run) state_d = IDLE;
      end
      STEP: begin
        if (tap_edge) begin
          tick_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = run ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
`ifdef COUNT_SAT_EN
    if (tick_q && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`else
    if (tick_q) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_q     <= 1'b1;
      step_q    <= 1'b1;
      tap_sel_q <= '0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_now;
      step_q    <= step_req;
      tap_sel_q <= tap_sel;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      running_q <= (state_d == RUN);
      cnt_q     <= cnt_d;
    end
  end

  assign tick       = tick_q;
  assign step_ack   = ack_q;
  assign running    = running_q;
  assign tick_count = cnt_q;
endmodule

// File: tb/tb_tick_enable_gen.sv
// Randomized bench for tick_enable_gen against a cycle-level behavioural model of the tick rules.
module tb_tick_enable_gen;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      divided_clocks;
  logic [4:0]       tap_sel;
  logic             run, step_req;
  logic             tick, step_ack, running;
  logic [CNT_W-1:0] tick_count;

  tick_enable_gen #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .divided_clocks(divided_clocks), .tap_sel(tap_sel),
    .run(run), .step_req(step_req), .tick(tick), .step_ack(step_ack),
    .running(running), .tick_count(tick_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 free-running, 2 waiting for one step tick.
  int m_mode, m_cnt, m_prev_tap, m_prev_bit, m_prev_step;
  bit m_tick, m_ack, m_last_tick;
  int win_ticks, win_acks;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_tick = 0; m_ack = 0;
    m_prev_tap = 0; m_prev_bit = 1; m_prev_step = 1; m_last_tick = 0;
  endtask

  task automatic model_clock();
    int  b;
    bit  rose, sr;
    b    = int'(divided_clocks[tap_sel]);
    rose = (b == 1) && (m_prev_bit == 0) && (int'(tap_sel) == m_prev_tap);
    sr   = (step_req == 1'b1) && (m_prev_step == 0);
    m_prev_bit = b; m_prev_tap = int'(tap_sel); m_prev_step = int'(step_req);
`ifdef COUNT_SAT_EN
    if (m_tick && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`else
    if (m_tick) m_cnt = (m_cnt + 1) % (1 << CNT_W);
`endif
    m_tick = 0; m_ack = 0;
    case (m_mode)
      0: if (run) m_mode = 1; else if (sr) m_mode = 2;
      1: begin m_tick = rose; if (!run) m_mode = 0; end
      default: if (rose) begin m_tick = 1; m_ack = 1; m_mode = run ? 1 : 0; end
    endcase
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      if (reset) model_reset(); else model_clock();
      #1;
      chk("tick", int'(tick), int'(m_tick));
      chk("step_ack", int'(step_ack), int'(m_ack));
      chk("running", int'(running), int'(m_mode == 1));
      chk("tick_count", int'(tick_count), m_cnt);
      if (m_last_tick) chk("tick_back_to_back", int'(tick), 0);
      m_last_tick = tick;
      win_ticks += int'(tick);
      win_acks  += int'(step_ack);
      divided_clocks = divided_clocks + 32'd1;
    end
  endtask

  initial begin
    divided_clocks = '0; tap_sel = '0; run = 0; step_req = 0;
    reset = 1; model_reset();
    #1;
    chk("reset_tick", int'(tick), 0);
    chk("reset_count", int'(tick_count), 0);
    chk("reset_running", int'(running), 0);
    cyc(2);
    reset = 0;

    // free run on bit 0: one tick every 2 clocks
    run = 1; tap_sel = 5'd0;
    cyc(6);
    win_ticks = 0; cyc(16); chk("tap0_ticks_per16", win_ticks, 8);
    cyc(20);

    // bit 3: one tick per 16 clocks
    tap_sel = 5'd3;
    cyc(20);
    win_ticks = 0; cyc(16); chk("tap3_ticks_per16", win_ticks, 1);
    win_ticks = 0; cyc(16); chk("tap3_ticks_per16b", win_ticks, 1);
    chk("tap3_running", int'(running), 1);

    // pause and single-step on bit 2
    run = 0; tap_sel = 5'd2;
    cyc(6);
    win_ticks = 0; win_acks = 0;
    step_req = 1; cyc(2); step_req = 0;
    cyc(8);
    chk("step_one_tick", win_ticks, 1);
    chk("step_one_ack", win_acks, 1);
    win_ticks = 0; cyc(64); chk("step_no_more_ticks", win_ticks, 0);

    // tap switch 3 -> 0 while bit 0 is high
    run = 1; tap_sel = 5'd3;
    cyc(20);
    for (int k = 0; k < 4 && divided_clocks[0] != 1'b1; k++) cyc(1);
    chk("switch_setup_bit0_high", int'(divided_clocks[0]), 1);
    tap_sel = 5'd0;
    win_ticks = 0; cyc(2); chk("switch_no_spurious", win_ticks, 0);
    cyc(10);

    // async reset mid-step
    run = 0; tap_sel = 5'd4;
    cyc(4);
    step_req = 1; cyc(3); step_req = 0;
    #3 reset = 1; #1;
    chk("areset_tick", int'(tick), 0);
    chk("areset_ack", int'(step_ack), 0);
    chk("areset_running", int'(running), 0);
    chk("areset_count", int'(tick_count), 0);
    model_reset();
    cyc(2);
    reset = 0;
    win_acks = 0; cyc(70); chk("areset_no_ack_after", win_acks, 0);

    // long run on bit 0 exercises counter wrap / saturation
    run = 1; tap_sel = 5'd0;
    cyc(60);

    // random control
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) tap_sel = 5'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0)  step_req = ~step_req;
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
